// File: rtl/pixel_dispatcher.sv
// Raster-order pixel job dispatcher feeding up to four cores round-robin.
// One job offered per cycle; a stalled core holds the whole stream.
module pixel_dispatcher #(
  parameter int COORD_W = 11
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               start,
  input  logic [COORD_W-1:0] frame_width,
  input  logic [COORD_W-1:0] frame_height,
  input  logic [2:0]         no_of_extra_cores,
  output logic [COORD_W-1:0] job_x_1,
  output logic [COORD_W-1:0] job_y_1,
  output logic               job_valid_1,
  input  logic               job_ready_1,
  output logic [COORD_W-1:0] job_x_2,
  output logic [COORD_W-1:0] job_y_2,
  output logic               job_valid_2,
  input  logic               job_ready_2,
  output logic [COORD_W-1:0] job_x_3,
  output logic [COORD_W-1:0] job_y_3,
  output logic               job_valid_3,
  input  logic               job_ready_3,
  output logic [COORD_W-1:0] job_x_4,
  output logic [COORD_W-1:0] job_y_4,
  output logic               job_valid_4,
  input  logic               job_ready_4,
  output logic               job_last,
  output logic               busy,
  output logic               frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  state_t             state;
  state_t             state_nx;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [COORD_W-1:0] wid;
  logic [COORD_W-1:0] hgt;
  logic [1:0]         ptr;
  logic [1:0]         last_core;
  logic               ready_cur;
  logic               at_eol;
  logic               at_last;
  logic               xfer;
  logic               zero_size;

  always_comb begin
    ready_cur = 1'b0;
    unique case (ptr)
      2'd0: ready_cur = job_ready_1;
      2'd1: ready_cur = job_ready_2;
      2'd2: ready_cur = job_ready_3;
      2'd3: ready_cur = job_ready_4;
      default: ready_cur = 1'b0;
    endcase
  end

  assign at_eol    = (x == wid - ONE);
  assign at_last   = (state == ISSUE) && at_eol
                     && (y == hgt - ONE);
  assign xfer      = (state == ISSUE) && ready_cur;
  assign zero_size = (frame_width == '0)
                     || (frame_height == '0);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = zero_size ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (xfer && at_last) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Coordinates return to 0 after the last job so idle outputs stay clean.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x         <= '0;
      y         <= '0;
      wid       <= '0;
      hgt       <= '0;
      ptr       <= '0;
      last_core <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        wid       <= frame_width;
        hgt       <= frame_height;
        last_core <= (no_of_extra_cores > 3'd3) ? 2'd3
                     : no_of_extra_cores[1:0];
        x         <= '0;
        y         <= '0;
        ptr       <= '0;
      end
    end else if (xfer) begin
      if (at_last) begin
        x   <= '0;
        y   <= '0;
        ptr <= '0;
      end else begin
        ptr <= (ptr == last_core) ? 2'd0 : ptr + 2'd1;
        if (at_eol) begin
          x <= '0;
          y <= y + ONE;
        end else begin
          x <= x + ONE;
        end
      end
    end
  end

  assign job_x_1 = x;
  assign job_x_2 = x;
  assign job_x_3 = x;
  assign job_x_4 = x;
  assign job_y_1 = y;
  assign job_y_2 = y;
  assign job_y_3 = y;
  assign job_y_4 = y;

  assign job_valid_1 = (state == ISSUE) && (ptr == 2'd0);
  assign job_valid_2 = (state == ISSUE) && (ptr == 2'd1);
  assign job_valid_3 = (state == ISSUE) && (ptr == 2'd2);
  assign job_valid_4 = (state == ISSUE) && (ptr == 2'd3);

  assign job_last   = at_last;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Directed bench for pixel_dispatcher: vector table plus
// stall, zero-size, busy-start and mid-frame reset sequences.
module tb_pixel_dispatcher;

  localparam int CW = 11;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] frame_width = '0;
  logic [CW-1:0] frame_height = '0;
  logic [2:0]    extra = '0;
  logic [CW-1:0] jx1, jx2, jx3, jx4;
  logic [CW-1:0] jy1, jy2, jy3, jy4;
  logic          jv1, jv2, jv3, jv4;
  logic          r1 = 1'b1, r2 = 1'b1;
  logic          r3 = 1'b1, r4 = 1'b1;
  logic          job_last, busy, frame_done;

  int n_vec = 0;
  int n_bad = 0;

  pixel_dispatcher #(.COORD_W(CW)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .start             (start),
    .frame_width       (frame_width),
    .frame_height      (frame_height),
    .no_of_extra_cores (extra),
    .job_x_1           (jx1),
    .job_y_1           (jy1),
    .job_valid_1       (jv1),
    .job_ready_1       (r1),
    .job_x_2           (jx2),
    .job_y_2           (jy2),
    .job_valid_2       (jv2),
    .job_ready_2       (r2),
    .job_x_3           (jx3),
    .job_y_3           (jy3),
    .job_valid_3       (jv3),
    .job_ready_3       (r3),
    .job_x_4           (jx4),
    .job_y_4           (jy4),
    .job_valid_4       (jv4),
    .job_ready_4       (r4),
    .job_last          (job_last),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit st;
    int w;
    int h;
    int e;
    int core;
    int x;
    int y;
    bit last;
  } vec_t;

  vec_t tab[17];

  task automatic chk(input string name,
                     input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int cur_core();
    int n;
    int c;
    n = 0;
    c = 0;
    if (jv1) begin n++; c = 1; end
    if (jv2) begin n++; c = 2; end
    if (jv3) begin n++; c = 3; end
    if (jv4) begin n++; c = 4; end
    return (n > 1) ? 9 : c;
  endfunction

  function automatic int x_all();
    if (jx1 == jx2 && jx1 == jx3 && jx1 == jx4)
      return int'(jx1);
    return -1;
  endfunction

  function automatic int y_all();
    if (jy1 == jy2 && jy1 == jy3 && jy1 == jy4)
      return int'(jy1);
    return -1;
  endfunction

  function automatic int any_out();
    return (|{jx1, jx2, jx3, jx4, jy1, jy2, jy3, jy4,
              jv1, jv2, jv3, jv4, job_last, busy,
              frame_done}) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_start(input int w, input int h,
                          input int e);
    frame_width  = CW'(w);
    frame_height = CW'(h);
    extra        = 3'(e);
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic check_job(input string tag, input int core,
                           input int x, input int y,
                           input bit last);
    chk({tag, " core"}, cur_core(), core);
    chk({tag, " x"}, x_all(), x);
    chk({tag, " y"}, y_all(), y);
    chk({tag, " last"}, int'(job_last), int'(last));
    chk({tag, " busy"}, int'(busy), 1);
  endtask

  task automatic check_done(input string tag);
    chk({tag, " done"}, int'(frame_done), 1);
    chk({tag, " done busy"}, int'(busy), 1);
    chk({tag, " done valid"}, cur_core(), 0);
    tick();
    chk({tag, " done pulse"}, int'(frame_done), 0);
    chk({tag, " idle busy"}, int'(busy), 0);
  endtask

  initial begin
    // frame A: 4x2, two cores
    tab[0]  = '{1, 4, 2, 1, 1, 0, 0, 0};
    tab[1]  = '{0, 0, 0, 0, 2, 1, 0, 0};
    tab[2]  = '{0, 0, 0, 0, 1, 2, 0, 0};
    tab[3]  = '{0, 0, 0, 0, 2, 3, 0, 0};
    tab[4]  = '{0, 0, 0, 0, 1, 0, 1, 0};
    tab[5]  = '{0, 0, 0, 0, 2, 1, 1, 0};
    tab[6]  = '{0, 0, 0, 0, 1, 2, 1, 0};
    tab[7]  = '{0, 0, 0, 0, 2, 3, 1, 1};
    // frame B: 5x1, extra=6 clamps to four cores
    tab[8]  = '{1, 5, 1, 6, 1, 0, 0, 0};
    tab[9]  = '{0, 0, 0, 0, 2, 1, 0, 0};
    tab[10] = '{0, 0, 0, 0, 3, 2, 0, 0};
    tab[11] = '{0, 0, 0, 0, 4, 3, 0, 0};
    tab[12] = '{0, 0, 0, 0, 1, 4, 0, 1};
    // frame C: 2x2, single core
    tab[13] = '{1, 2, 2, 0, 1, 0, 0, 0};
    tab[14] = '{0, 0, 0, 0, 1, 1, 0, 0};
    tab[15] = '{0, 0, 0, 0, 1, 0, 1, 0};
    tab[16] = '{0, 0, 0, 0, 1, 1, 1, 1};

    #12;
    chk("reset outputs", any_out(), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    chk("idle outputs", any_out(), 0);

    for (int i = 0; i < 17; i++) begin
      if (tab[i].st) do_start(tab[i].w, tab[i].h, tab[i].e);
      check_job($sformatf("vec%0d", i), tab[i].core,
                tab[i].x, tab[i].y, tab[i].last);
      tick();
      if (tab[i].last) check_done($sformatf("vec%0d", i));
    end

    // core 3 stalls for five cycles on (2,0)
    do_start(3, 3, 3);
    for (int k = 0; k < 9; k++) begin
      if (k == 2) begin
        r3 = 1'b0;
        for (int s = 0; s < 5; s++) begin
          check_job($sformatf("stall%0d", s), 3, 2, 0, 0);
          chk("stall v4", int'(jv4), 0);
          tick();
        end
        r3 = 1'b1;
      end
      check_job($sformatf("rr%0d", k), (k % 4) + 1,
                k % 3, k / 3, k == 8);
      tick();
    end
    check_done("rr");

    // zero-size frames issue nothing
    do_start(0, 3, 1);
    check_done("zw");
    do_start(4, 0, 0);
    check_done("zh");

    // start and new config while busy are ignored
    do_start(3, 2, 1);
    for (int k = 0; k < 6; k++) begin
      start        = (k < 3);
      frame_width  = CW'(5);
      frame_height = CW'(1);
      extra        = 3'd3;
      check_job($sformatf("bs%0d", k), (k % 2) + 1,
                k % 3, k / 3, k == 5);
      tick();
    end
    start = 1'b0;
    check_done("bs");

    // reset at pixel 3 of a 4x4 frame
    do_start(4, 4, 0);
    for (int k = 0; k < 3; k++) begin
      check_job($sformatf("mr%0d", k), 1, k, 0, 0);
      tick();
    end
    check_job("mr3", 1, 3, 0, 0);
    #1 aresetn = 1'b0;
    #1 chk("async reset outputs", any_out(), 0);
    tick();
    chk("held reset outputs", any_out(), 0);
    #2 aresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post reset done%0d", k),
          int'(frame_done), 0);
      chk($sformatf("post reset busy%0d", k), int'(busy), 0);
    end
    do_start(4, 4, 2);
    check_job("restart", 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
